// File: rtl/fmul_72bit_fract_mul_iter.sv
// fmul_72bit_fract_mul_iter: front-end multiply stage of the 72-bit FP multiplier.
// Unpacks operands, forms sign/exponent/flags and an iterative 120-bit mantissa product.
module fmul_72bit_fract_mul_iter #(
    parameter int RADIX_BITS = 4,
    parameter int EXP_BIAS   = 2047
) (
    input  logic         iCLOCK,
    input  logic         iRESET_SYNC,
    input  logic         iDATA_VALID,
    output logic         oDATA_BUSY,
    input  logic [71:0]  iDATA_A,
    input  logic [71:0]  iDATA_B,
    output logic         oDATA_VALID,
    input  logic         iDATA_BUSY,
    output logic         oDATA_SIGN,
    output logic [12:0]  oDATA_EXP,
    output logic [119:0] oDATA_FRACT,
    output logic         oDATA_EXCEPT_EXP_A0,
    output logic         oDATA_EXCEPT_EXP_B0,
    output logic         oDATA_EXCEPT_EXP_A1,
    output logic         oDATA_EXCEPT_EXP_B1,
    output logic         oDATA_EXCEPT_FRACT_A0,
    output logic         oDATA_EXCEPT_FRACT_B0
);

    localparam int K = 60 / RADIX_BITS;
    localparam logic [5:0] LAST = 6'(K - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic                  accept;
    logic                  last;
    logic [11:0]           exp_a;
    logic [11:0]           exp_b;
    logic [12:0]           exp_sum;
    logic [59:0]           ma;
    logic [59:0]           mb;
    logic                  sign_r;
    logic [12:0]           exp_r;
    logic [5:0]            flag_r;
    logic [119:0]          acc;
    logic [119:0]          acc_next;
    logic [5:0]            cnt;
    logic [RADIX_BITS-1:0] digit;

    assign exp_a   = iDATA_A[70:59];
    assign exp_b   = iDATA_B[70:59];
    assign exp_sum = {1'b0, exp_a} + {1'b0, exp_b} - 13'(EXP_BIAS);
    assign last    = (cnt == LAST);

    // mb is shifted left each cycle, so its top slice is the next digit
    assign digit    = mb[59 -: RADIX_BITS];
    assign acc_next = (acc << RADIX_BITS)
                    + ({60'd0, ma} * {{(120 - RADIX_BITS){1'b0}}, digit});

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        oDATA_BUSY = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (iDATA_VALID) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                oDATA_BUSY = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (iDATA_BUSY) begin
                    oDATA_BUSY = 1'b1;
                end else if (iDATA_VALID) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            ma                    <= '0;
            mb                    <= '0;
            sign_r                <= 1'b0;
            exp_r                 <= '0;
            flag_r                <= '0;
            acc                   <= '0;
            cnt                   <= '0;
            oDATA_VALID           <= 1'b0;
            oDATA_SIGN            <= 1'b0;
            oDATA_EXP             <= '0;
            oDATA_FRACT           <= '0;
            oDATA_EXCEPT_EXP_A0   <= 1'b0;
            oDATA_EXCEPT_EXP_B0   <= 1'b0;
            oDATA_EXCEPT_EXP_A1   <= 1'b0;
            oDATA_EXCEPT_EXP_B1   <= 1'b0;
            oDATA_EXCEPT_FRACT_A0 <= 1'b0;
            oDATA_EXCEPT_FRACT_B0 <= 1'b0;
        end else begin
            if (accept) begin
                ma     <= {(exp_a != 12'd0), iDATA_A[58:0]};
                mb     <= {(exp_b != 12'd0), iDATA_B[58:0]};
                sign_r <= iDATA_A[71] ^ iDATA_B[71];
                exp_r  <= exp_sum;
                flag_r <= {(exp_a == 12'd0), (exp_b == 12'd0),
                           (exp_a == 12'hFFF), (exp_b == 12'hFFF),
                           (iDATA_A[58:0] == 59'd0),
                           (iDATA_B[58:0] == 59'd0)};
                acc    <= '0;
                cnt    <= '0;
            end else if (state == CALC) begin
                acc <= acc_next;
                mb  <= mb << RADIX_BITS;
                cnt <= cnt + 6'd1;
            end

            if (state == CALC && last) begin
                oDATA_VALID           <= 1'b1;
                oDATA_SIGN            <= sign_r;
                oDATA_EXP             <= exp_r;
                oDATA_FRACT           <= acc_next;
                oDATA_EXCEPT_EXP_A0   <= flag_r[5];
                oDATA_EXCEPT_EXP_B0   <= flag_r[4];
                oDATA_EXCEPT_EXP_A1   <= flag_r[3];
                oDATA_EXCEPT_EXP_B1   <= flag_r[2];
                oDATA_EXCEPT_FRACT_A0 <= flag_r[1];
                oDATA_EXCEPT_FRACT_B0 <= flag_r[0];
            end else if (state == DONE && !iDATA_BUSY) begin
                oDATA_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fmul_72bit_fract_mul_iter.sv
// tb_fmul_72bit_fract_mul_iter: scoreboard bench for the iterative multiply stage,
// three instances with radix 1, 4 and 12 each running directed then random ops.
module tb_fmul_72bit_fract_mul_iter;

    typedef struct {
        logic         sign;
        logic [12:0]  exp;
        logic [119:0] fract;
        logic [5:0]   flags;
        int           acc_cyc;
    } exp_t;

    localparam logic [71:0] ONE  = 72'h3FF800000000000000;
    localparam logic [71:0] H15  = 72'h3FFC00000000000000;
    localparam logic [71:0] NEG2 = 72'hC00000000000000000;
    localparam logic [71:0] BIGB = 72'h7FF800000000000000;

    logic clk = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic all_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, req);
    endtask

    function automatic exp_t model(input logic [71:0] a,
                                   input logic [71:0] b, input int c);
        exp_t         e;
        logic [119:0] pa;
        logic [119:0] pb;
        int           s;
        pa = 120'(a[58:0]);
        pb = 120'(b[58:0]);
        if (a[70:59] != 0) pa = pa + (120'd1 << 59);
        if (b[70:59] != 0) pb = pb + (120'd1 << 59);
        s = int'(a[70:59]) + int'(b[70:59]) - 2047;
        e.sign    = a[71] ^ b[71];
        e.exp     = s[12:0];
        e.fract   = pa * pb;
        e.flags   = {a[70:59] == 0, b[70:59] == 0,
                     a[70:59] == 12'hFFF, b[70:59] == 12'hFFF,
                     a[58:0] == 0, b[58:0] == 0};
        e.acc_cyc = c;
        return e;
    endfunction

    function automatic logic [71:0] rnd_op();
        logic [95:0] r;
        r = {$urandom, $urandom, $urandom};
        case ($urandom_range(0, 7))
            0: r[70:59] = '0;
            1: r[70:59] = '1;
            2: r[58:0]  = '0;
            default: ;
        endcase
        return r[71:0];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_rx
        localparam int R = (g == 0) ? 1 : (g == 1) ? 4 : 12;
        localparam int K = 60 / R;
        localparam int N = 20000 / (K + 5);

        logic         rst = 1'b1;
        logic         vld = 1'b0;
        logic [71:0]  da = '0;
        logic [71:0]  db = '0;
        logic         bz = 1'b0;
        logic         busy_o, valid_o, sign_o;
        logic [12:0]  exp_o;
        logic [119:0] fract_o;
        logic         ea0, eb0, ea1, eb1, fa0, fb0;
        logic [5:0]   fl;
        exp_t         q[$];
        bit           head_seen = 1'b0;
        bit           done = 1'b0;

        assign fl = {ea0, eb0, ea1, eb1, fa0, fb0};

        fmul_72bit_fract_mul_iter #(.RADIX_BITS(R), .EXP_BIAS(2047)) dut (
            .iCLOCK(clk), .iRESET_SYNC(rst),
            .iDATA_VALID(vld), .oDATA_BUSY(busy_o),
            .iDATA_A(da), .iDATA_B(db),
            .oDATA_VALID(valid_o), .iDATA_BUSY(bz),
            .oDATA_SIGN(sign_o), .oDATA_EXP(exp_o), .oDATA_FRACT(fract_o),
            .oDATA_EXCEPT_EXP_A0(ea0), .oDATA_EXCEPT_EXP_B0(eb0),
            .oDATA_EXCEPT_EXP_A1(ea1), .oDATA_EXCEPT_EXP_B1(eb1),
            .oDATA_EXCEPT_FRACT_A0(fa0), .oDATA_EXCEPT_FRACT_B0(fb0)
        );

        task automatic drive(input bit r, input bit v, input logic [71:0] a,
                             input logic [71:0] b, input bit z,
                             output bit bsy);
            rst = r; vld = v; da = a; db = b; bz = z;
            @(negedge clk);
            bsy = busy_o;
            if (r) q.delete();
            else if (v && !busy_o) q.push_back(model(a, b, cyc));
            @(posedge clk);
            #1;
        endtask

        task automatic drain();
            bit b;
            int n;
            n = 0;
            while (q.size() != 0 && n < 4 * K + 20) begin
                drive(0, 0, '0, '0, 0, b);
                n++;
            end
            if (q.size() != 0) begin
                n_checks++;
                $display("FAIL r%0d drain: got %0d pending expected 0", R, q.size());
                q.delete();
            end
        endtask

        task automatic chk_zero(input string nm);
            check($sformatf("r%0d %s valid", R, nm), valid_o, 0);
            check($sformatf("r%0d %s busy", R, nm), busy_o, 0);
            check($sformatf("r%0d %s fract", R, nm), fract_o, 0);
            check($sformatf("r%0d %s exp", R, nm), {exp_o, sign_o, fl}, 0);
        endtask

        // monitor: compare every presented result against the queue head
        initial begin
            forever begin
                @(negedge clk);
                if (rst) head_seen = 1'b0;
                else if (valid_o === 1'b1) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        $display("FAIL r%0d unexpected_valid: got 1 expected 0", R);
                    end else begin
                        check($sformatf("r%0d sign", R), sign_o, q[0].sign);
                        check($sformatf("r%0d exp", R), exp_o, q[0].exp);
                        check($sformatf("r%0d fract", R), fract_o, q[0].fract);
                        check($sformatf("r%0d flags", R), fl, q[0].flags);
                        if (!head_seen) begin
                            check($sformatf("r%0d latency_cyc", R), cyc,
                                  q[0].acc_cyc + 1 + K);
                            head_seen = 1'b1;
                        end
                        if (!bz) begin
                            void'(q.pop_front());
                            head_seen = 1'b0;
                        end
                    end
                end
            end
        end

        initial begin
            bit b;
            int n;
            int issued;
            int guard;
            bit v;
            bit z;
            @(posedge clk);
            #1;
            repeat (3) drive(1, 1, ONE, ONE, 0, b);
            chk_zero("reset");

            drive(0, 1, ONE, ONE, 0, b);
            drain();
            check($sformatf("r%0d one fract", R), fract_o, 120'd1 << 118);
            check($sformatf("r%0d one exp", R), exp_o, 13'h07FF);
            check($sformatf("r%0d idle valid", R), valid_o, 0);

            drive(0, 1, H15, H15, 0, b);
            drain();
            check($sformatf("r%0d h15 fract", R), fract_o,
                  (120'd1 << 119) | (120'd1 << 116));

            drive(0, 1, NEG2, ONE, 0, b);
            drain();
            check($sformatf("r%0d neg2 sign_exp", R), {sign_o, exp_o},
                  {1'b1, 13'h0800});

            drive(0, 1, 72'h0, BIGB, 0, b);
            drain();
            check($sformatf("r%0d flg flags", R), fl, 6'b100111);
            check($sformatf("r%0d flg exp_fract", R), {exp_o, fract_o},
                  {13'h0800, 120'd0});

            // backpressure: stalled DONE ignores new operands
            drive(0, 1, ONE, NEG2, 1, b);
            n = 0;
            while (valid_o !== 1'b1 && n < K + 4) begin
                drive(0, 0, '0, '0, 1, b);
                n++;
            end
            check($sformatf("r%0d stall reach_valid", R), valid_o, 1);
            for (int i = 0; i < 10; i++) begin
                drive(0, 1, H15, H15, 1, b);
                check($sformatf("r%0d stall busy", R), b, 1);
            end
            drive(0, 1, H15, ONE, 0, b);
            check($sformatf("r%0d release busy", R), b, 0);
            drain();

            // reset aborts an op in flight
            drive(0, 1, rnd_op(), rnd_op(), 0, b);
            for (int i = 0; i < K / 2; i++) drive(0, 0, '0, '0, 0, b);
            drive(1, 0, '0, '0, 0, b);
            chk_zero("midreset");
            for (int i = 0; i < K + 5; i++) drive(0, 0, '0, '0, 0, b);
            check($sformatf("r%0d midreset quiet", R), valid_o, 0);
            drive(0, 1, H15, NEG2, 0, b);
            drain();

            issued = 0;
            guard = 0;
            while (issued < N && guard < N * (K + 20)) begin
                v = 1'($urandom_range(0, 1));
                z = ($urandom_range(0, 2) == 0);
                drive(0, v, rnd_op(), rnd_op(), z, b);
                if (v && !b) issued++;
                guard++;
            end
            check($sformatf("r%0d random issued", R), issued, N);
            drain();
            done = 1'b1;
        end
    end

    assign all_done = g_rx[0].done & g_rx[1].done & g_rx[2].done;

    initial begin
        fork
            wait (all_done === 1'b1);
            repeat (90000) @(posedge clk);
        join_any
        if (all_done !== 1'b1) begin
            n_checks++;
            $display("FAIL global_timeout: got 0 expected 1");
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
